// File: rtl/display_pkg.sv
// display_pkg: shared sizes and FSM state type for the display arbiter.
package display_pkg;
    localparam int NUM_REQ     = 4;
    localparam int DIGIT_COUNT = 6;
    localparam int DATA_W      = 4 * DIGIT_COUNT;
    localparam int LED_W       = 5;
    localparam int CNT_W       = 26;
    typedef enum logic {IDLE, HOLD} arb_state_t;
endpackage

// File: rtl/display_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting one past the last winner.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);
    always_comb begin
        valid = |req;
        idx = '0;
        // scan farthest-first so the nearest requester after last wins
        for (int k = 3; k >= 0; k--)
            if (req[last + 2'(k + 1)]) idx = last + 2'(k + 1);
    end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: grants one requester at a time to the hex/LED display and
// holds its contents for HOLD_CYCLES before accepting the next request.
module display_arbiter #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int NUM_REQ     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*24-1:0] req_data,
    input  logic [NUM_REQ*5-1:0]  req_leds,
    output logic [NUM_REQ-1:0]    grant,
    output logic [23:0]           disp_value,
    output logic [4:0]            disp_leds,
    output logic [1:0]            disp_src,
    output logic                  busy
);
    import display_pkg::*;

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last_src;
    logic             valid;
    logic [1:0]       idx;

    rr_pick u_pick (
        .req  (req),
        .last (last_src),
        .valid(valid),
        .idx  (idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            disp_value <= '0;
            disp_leds  <= '0;
            disp_src   <= '0;
            last_src   <= 2'd3;
        end else begin
            grant <= '0;
            if (state == IDLE) begin
                if (valid) begin
                    state      <= HOLD;
                    cnt        <= CNT_W'(HOLD_CYCLES - 1);
                    busy       <= 1'b1;
                    grant      <= NUM_REQ'(1) << idx;
                    disp_value <= req_data[idx*DATA_W +: DATA_W];
                    disp_leds  <= req_leds[idx*LED_W +: LED_W];
                    disp_src   <= idx;
                    last_src   <= idx;
                end
            end else if (cnt == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: scoreboard bench; expected grants are queued as requests
// are raised and popped when the arbiter acknowledges.
module tb_display_arbiter;
    typedef struct packed {
        logic [1:0]  src;
        logic [23:0] value;
        logic [4:0]  leds;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [95:0] req_data = '0;
    logic [19:0] req_leds = '0;
    logic [3:0]  grant;
    logic [23:0] disp_value;
    logic [4:0]  disp_leds;
    logic [1:0]  disp_src;
    logic        busy;

    logic [23:0] vals [4];
    logic [4:0]  ledv [4];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          pushed = 0;
    int          grants_seen = 0;
    int          cyc = 0;

    display_arbiter #(.HOLD_CYCLES(4), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_leds  (req_leds),
        .grant     (grant),
        .disp_value(disp_value),
        .disp_leds (disp_leds),
        .disp_src  (disp_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (grant !== '0) grants_seen <= grants_seen + 1;

    task automatic set_src(input int i, input logic [23:0] v, input logic [4:0] l);
        req_data[24*i +: 24] = v;
        req_leds[5*i +: 5] = l;
        vals[i] = v;
        ledv[i] = l;
    endtask

    task automatic expect_req(input int i);
        sb.push_back({2'(i), vals[i], ledv[i]});
        pushed++;
    endtask

    task automatic wait_grant(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget && at < 0; n++) begin
            @(negedge clk);
            if (grant !== '0) at = cyc;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy !== 1'b0; n++) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) set_src(i, '0, '0);
        apply_reset();
        checks++;
        if (disp_value !== 24'h000000) begin errors++; $display("FAIL reset_value: got %h, required 000000", disp_value); end
        checks++;
        if (disp_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d, required 0", disp_src); end
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b, required 0000", grant); end
        checks++;
        if (busy !== 1'b0 || disp_leds !== 5'h00) begin errors++; $display("FAIL reset_busy_leds: got busy=%b leds=%h, required 0 00", busy, disp_leds); end
    endtask

    task automatic test_single();
        int t0, at, n;
        logic extra;
        exp_t e;
        set_src(0, 24'h12ABCD, 5'h15);
        req = 4'b0001;
        expect_req(0);
        t0 = cyc;
        wait_grant(4, at);
        checks++;
        if (at != t0 + 1) begin errors++; $display("FAIL single_latency: grant at cycle %0d, required %0d", at, t0 + 1); end
        if (at >= 0) begin
            req[0] = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({grant, disp_src, disp_value, disp_leds} !== {4'b0001 << e.src, e.src, e.value, e.leds}) begin
                errors++;
                $display("FAIL single_grant: got grant=%b src=%0d value=%h leds=%h, required grant=%b src=%0d value=%h leds=%h",
                         grant, disp_src, disp_value, disp_leds, 4'b0001 << e.src, e.src, e.value, e.leds);
            end
        end
        n = 0;
        extra = 1'b0;
        while (busy === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
            if (grant !== '0) extra = 1'b1;
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL single_busy_len: busy for %0d cycles, required 4", n); end
        checks++;
        if (extra !== 1'b0) begin errors++; $display("FAIL single_grant_pulse: extra grant seen, required single-cycle grant"); end
        repeat (2) @(negedge clk);
        checks++;
        if (disp_value !== 24'h12ABCD || disp_leds !== 5'h15 || busy !== 1'b0 || grant !== '0)
            begin errors++; $display("FAIL idle_keep: got value=%h leds=%h busy=%b grant=%b, required 12abcd 15 0 0000", disp_value, disp_leds, busy, grant); end
    endtask

    task automatic test_simultaneous();
        int t0, at, prev;
        exp_t e;
        apply_reset();
        for (int i = 0; i < 4; i++) set_src(i, 24'(i + 1) * 24'h111111, 5'(3 * i + 1));
        req = 4'b1111;
        for (int i = 0; i < 4; i++) expect_req(i);
        t0 = cyc;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_grant(8, at);
            checks++;
            if (at != (i == 0 ? t0 + 1 : prev + 5)) begin errors++; $display("FAIL simul_timing_%0d: grant at cycle %0d, required %0d", i, at, i == 0 ? t0 + 1 : prev + 5); end
            if (at < 0) break;
            e = sb.pop_front();
            checks++;
            if ({grant, disp_src, disp_value, disp_leds} !== {4'b0001 << e.src, e.src, e.value, e.leds}) begin
                errors++;
                $display("FAIL simul_grant_%0d: got grant=%b src=%0d value=%h leds=%h, required grant=%b src=%0d value=%h leds=%h",
                         i, grant, disp_src, disp_value, disp_leds, 4'b0001 << e.src, e.src, e.value, e.leds);
            end
            req = req & ~grant;
            prev = at;
        end
    endtask

    task automatic test_wrap();
        int t0, at, prev;
        exp_t e;
        wait_idle();
        req = 4'b1001;
        expect_req(0);
        expect_req(3);
        t0 = cyc;
        prev = 0;
        for (int i = 0; i < 2; i++) begin
            wait_grant(8, at);
            checks++;
            if (at != (i == 0 ? t0 + 1 : prev + 5)) begin errors++; $display("FAIL wrap_timing_%0d: grant at cycle %0d, required %0d", i, at, i == 0 ? t0 + 1 : prev + 5); end
            if (at < 0) break;
            e = sb.pop_front();
            checks++;
            if ({grant, disp_src, disp_value, disp_leds} !== {4'b0001 << e.src, e.src, e.value, e.leds}) begin
                errors++;
                $display("FAIL wrap_grant_%0d: got grant=%b src=%0d value=%h, required grant=%b src=%0d value=%h",
                         i, grant, disp_src, disp_value, 4'b0001 << e.src, e.src, e.value);
            end
            req = req & ~grant;
            prev = at;
        end
    endtask

    task automatic test_frozen();
        int at, n, t_idle;
        logic changed;
        exp_t e;
        wait_idle();
        set_src(0, 24'h5A5A5A, 5'h0C);
        req = 4'b0001;
        expect_req(0);
        wait_grant(4, at);
        if (at >= 0) begin
            req[0] = 1'b0;
            e = sb.pop_front();
            checks++;
            if (disp_value !== e.value || grant !== 4'b0001) begin errors++; $display("FAIL frozen_first: got grant=%b value=%h, required 0001 %h", grant, disp_value, e.value); end
        end
        @(negedge clk);
        set_src(1, 24'hFFFFFF, 5'h1F);
        req = 4'b0010;
        expect_req(1);
        n = 0;
        changed = 1'b0;
        while (busy === 1'b1 && n < 10) begin
            if (disp_value !== 24'h5A5A5A || grant !== '0) changed = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (changed !== 1'b0) begin errors++; $display("FAIL frozen_hold: display or grant changed during HOLD, required frozen"); end
        checks++;
        if (disp_value !== 24'h5A5A5A) begin errors++; $display("FAIL frozen_idle_entry: got %h, required 5a5a5a", disp_value); end
        t_idle = cyc;
        wait_grant(3, at);
        checks++;
        if (at != t_idle + 1) begin errors++; $display("FAIL frozen_latency: grant at cycle %0d, required %0d", at, t_idle + 1); end
        if (at >= 0) begin
            req[1] = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({grant, disp_src, disp_value, disp_leds} !== {4'b0001 << e.src, e.src, e.value, e.leds}) begin
                errors++;
                $display("FAIL frozen_second: got grant=%b src=%0d value=%h leds=%h, required grant=%b src=%0d value=%h leds=%h",
                         grant, disp_src, disp_value, disp_leds, 4'b0001 << e.src, e.src, e.value, e.leds);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int t0, at;
        exp_t e;
        wait_idle();
        set_src(2, 24'h345678, 5'h0A);
        req = 4'b0100;
        expect_req(2);
        wait_grant(4, at);
        if (at >= 0) begin
            req[2] = 1'b0;
            e = sb.pop_front();
            checks++;
            if (disp_value !== e.value || grant !== 4'b0100) begin errors++; $display("FAIL rst_hold_grant: got grant=%b value=%h, required 0100 %h", grant, disp_value, e.value); end
        end
        @(negedge clk);
        rst = 1'b1;
        set_src(0, 24'hC0FFEE, 5'h03);
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || disp_value !== 24'h000000 || grant !== 4'b0000 || disp_src !== 2'd0)
            begin errors++; $display("FAIL rst_hold_abort: got busy=%b value=%h grant=%b src=%0d, required 0 000000 0000 0", busy, disp_value, grant, disp_src); end
        rst = 1'b0;
        expect_req(0);
        t0 = cyc;
        wait_grant(3, at);
        checks++;
        if (at != t0 + 1) begin errors++; $display("FAIL rst_release_latency: grant at cycle %0d, required %0d", at, t0 + 1); end
        if (at >= 0) begin
            req = '0;
            e = sb.pop_front();
            checks++;
            if ({grant, disp_src, disp_value, disp_leds} !== {4'b0001 << e.src, e.src, e.value, e.leds}) begin
                errors++;
                $display("FAIL rst_release_grant: got grant=%b src=%0d value=%h leds=%h, required grant=%b src=%0d value=%h leds=%h",
                         grant, disp_src, disp_value, disp_leds, 4'b0001 << e.src, e.src, e.value, e.leds);
            end
        end
    endtask

    task automatic test_totals();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drained: %0d grants outstanding, required 0", sb.size()); end
        checks++;
        if (grants_seen != pushed) begin errors++; $display("FAIL grant_count: saw %0d grants, required %0d", grants_seen, pushed); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wrap();
        test_frozen();
        test_reset_mid_hold();
        test_totals();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, minimum hold time in clk cycles after each grant (legal range 1 to 2^26-1).
REQ-002 Parameter NUM_REQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-003 Port clk  input  1  single clock; every register in the block updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port req  input  4  per-requester display request; level-sensitive.
REQ-006 Port req_data  input  96  per-requester 24-bit hex value; requester i occupies bits [24i+23:24i].
REQ-007 Port req_leds  input  20  per-requester 5-bit LED pattern; requester i occupies bits [5i+4:5i].
REQ-008 Port grant  output  4  one-hot, single-cycle acknowledge to the requester whose data was latched.
REQ-009 Port disp_value  output  24  registered value for the six-digit hex decoder; bits [23:20] drive the leftmost digit.
REQ-010 Port disp_leds  output  5  registered LED pattern for the LED bank.
REQ-011 Port disp_src  output  2  index of the requester that owns the current display contents.
REQ-012 Port busy  output  1  high while the hold window is active.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and HOLD.
REQ-014 In IDLE with req==0, the FSM SHALL stay in IDLE, and all display outputs SHALL keep their last values.
REQ-015 In IDLE with any req bit set in cycle N, the arbiter SHALL pick a winner round-robin, searching from (last_src+1) mod 4 upward.
REQ-016 For a cycle-N request, disp_value, disp_leds, disp_src and grant SHALL update in cycle N+1, giving a latency of 1 cycle.
REQ-017 grant SHALL be high for exactly one cycle per acceptance and SHALL be zero in every other cycle.
REQ-018 On acceptance, the FSM SHALL enter HOLD with the hold counter loaded to HOLD_CYCLES-1, and busy SHALL be high from cycle N+1.
REQ-019 In HOLD, the counter SHALL decrement by 1 per cycle; when the counter is 0, the next state SHALL be IDLE and busy SHALL deassert.
REQ-020 With HOLD_CYCLES=1, HOLD SHALL last one cycle, so back-to-back grants occur every 2 cycles.
REQ-021 All req inputs SHALL be ignored during HOLD, and display outputs SHALL remain frozen.
REQ-022 Handshake: a requester holds req and its data stable until it sees its grant, then drops req.
REQ-023 If req is withdrawn before grant, no grant SHALL issue to that requester.
REQ-024 If req is still high after grant, the requester SHALL be treated as requesting again and becomes eligible at the next IDLE.
REQ-025 When multiple requests arrive in the same cycle, exactly one winner SHALL be granted; the others wait without any loss of request state beyond their own req level.
REQ-026 The round-robin pointer SHALL wrap from 3 to 0, and last_src SHALL update only on grant.
REQ-027 The hold counter SHALL be 26 bits wide and unsigned, and SHALL never underflow.

Reset
REQ-028 While rst is high at a clk edge, the block SHALL force: state=IDLE, counter=0, grant=0, busy=0, disp_value=24'h000000, disp_leds=0, disp_src=0, last_src=3 (so requester 0 has first priority).
REQ-029 An rst asserted during HOLD SHALL abort the hold window immediately, and no grant SHALL issue in the reset cycle.
REQ-030 In the first cycle after rst deasserts, req SHALL be sampled normally.

Structure
REQ-031 Package display_pkg SHALL hold NUM_REQ, DIGIT_COUNT=6, the data width of 24, the LED width of 5, and the arb_state_t enum (IDLE, HOLD).
REQ-032 The combinational round-robin pick SHALL be a sub-module named rr_pick, with inputs req[3:0] and last[1:0] and outputs valid and idx[1:0].
REQ-033 The FSM, counter and output registers SHALL live in display_arbiter.
REQ-034 display_arbiter SHALL NOT instantiate the hex decoder; its outputs connect to the decoder at the top level.

Verification (HOLD_CYCLES=4)
REQ-035 Reset check: after reset, disp_value SHALL be 000000, disp_src SHALL be 0, grant SHALL be 0 and busy SHALL be 0.
REQ-036 Single request: req=0001 with data0=24'h12ABCD and leds0=5'h15 -> next cycle grant=0001, disp_value=12ABCD, disp_leds=15, and busy high for 4 cycles.
REQ-037 Simultaneous requests: req=1111 held, with each requester dropping req on its grant -> grant order 0,1,2,3, with successive grants 5 cycles apart.
REQ-038 Pointer wrap: with last_src=3 and req=1001 -> requester 0 wins; after it drops req, requester 3 is granted next.
REQ-039 Frozen during HOLD: req1 asserted with data 24'hFFFFFF during HOLD -> disp_value unchanged until HOLD ends, then FFFFFF is displayed one cycle after IDLE is entered.
REQ-040 Reset mid-HOLD: rst pulsed in the second cycle of HOLD -> next cycle state=IDLE, disp_value=000000, busy=0, and no spurious grant.
